pc_gen: RTL and testbench



---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_redirect_buf.sv | 34 +++
 rtl/pc_gen.sv | 123 ++++++++++++
 tb/tb_pc_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC generator.
package pc_pkg;

  // RUN: no buffered redirect; HOLD: a branch is parked waiting for stall release.
  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } pc_state_t;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_4180;
  localparam int unsigned STEP_DEF      = 4;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry redirect buffer: holds a branch target that arrived during a stall.
// Load overwrites any older entry; clear drops it.
module pc_redirect_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] target
);

  logic             valid_q;
  logic [WIDTH-1:0] target_q;

  // Entry register: load wins over clear, a newer branch replaces the older one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      target_q <= '0;
    end else if (load) begin
      valid_q  <= 1'b1;
      target_q <= din;
    end else if (clear) begin
      valid_q  <= 1'b0;
    end
  end

  assign valid  = valid_q;
  assign target = target_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter generator with exception entry/return and a
// one-entry redirect buffer for branches that arrive during a stall.
// Optional macro PC_ALIGN_CHECK_EN: load targets unmodified and flag misaligned
// fetches on fetch_adel; otherwise targets are word-aligned and fetch_adel is 0.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(RESET_VEC_DEF),
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(EXC_VEC_DEF),
  parameter int unsigned       STEP      = STEP_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             redirect_pending,
  output logic             fetch_adel
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             buf_load, buf_clear, buf_valid;
  logic [WIDTH-1:0] buf_target;
  logic [WIDTH-1:0] br_fix, pend_fix, eret_fix;

`ifdef PC_ALIGN_CHECK_EN
  assign br_fix   = br_target;
  assign pend_fix = buf_target;
  assign eret_fix = epc_q;
`else
  // Force word alignment on every redirect load.
  assign br_fix   = br_target  & ~WIDTH'(3);
  assign pend_fix = buf_target & ~WIDTH'(3);
  assign eret_fix = epc_q      & ~WIDTH'(3);
`endif

  pc_redirect_buf #(
    .WIDTH (WIDTH)
  ) u_redirect_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (buf_load),
    .clear   (buf_clear),
    .din     (br_target),
    .valid   (buf_valid),
    .target  (buf_target)
  );

  // Next-state: exception > eret > branch > buffered branch > sequential > hold.
  always_comb begin
    pc_d      = pc_q;
    epc_d     = epc_q;
    state_d   = state_q;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    if (exc_req) begin
      pc_d      = EXC_VEC;
      epc_d     = exc_pc;
      buf_clear = 1'b1;
      state_d   = RUN;
    end else if (eret_req) begin
      pc_d      = eret_fix;
      buf_clear = 1'b1;
      state_d   = RUN;
    end else if (br_valid && !stall) begin
      pc_d      = br_fix;
      buf_clear = 1'b1;
      state_d   = RUN;
    end else if (br_valid && stall) begin
      buf_load  = 1'b1;
      state_d   = HOLD;
    end else if (state_q == HOLD && !stall) begin
      pc_d      = pend_fix;
      buf_clear = 1'b1;
      state_d   = RUN;
    end else if (!stall) begin
      pc_d      = pc_q + WIDTH'(STEP);
    end
  end

  // State, PC and EPC registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic adel_q;

  // Misalignment flag tracks the low bits of the PC being loaded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adel_q <= 1'b0;
    end else begin
      adel_q <= |pc_d[1:0];
    end
  end

  assign fetch_adel = adel_q;
`else
  assign fetch_adel = 1'b0;
`endif

  assign pc               = pc_q;
  assign epc              = epc_q;
  assign redirect_pending = buf_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the redirect rules.
module tb_pc_gen;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        eret_req;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        redirect_pending;
  logic        fetch_adel;

  int n_checks;
  int n_errors;

  // Reference model state.
  logic [31:0] m_pc, m_epc, m_pt;
  logic        m_pv;

  pc_gen dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .exc_req          (exc_req),
    .exc_pc           (exc_pc),
    .eret_req         (eret_req),
    .pc               (pc),
    .epc              (epc),
    .redirect_pending (redirect_pending),
    .fetch_adel       (fetch_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic logic exp_adel();
`ifdef PC_ALIGN_CHECK_EN
    return m_pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc  = 32'h0000_3000;
    m_epc = 32'h0;
    m_pt  = 32'h0;
    m_pv  = 1'b0;
  endtask

  // Apply the priority rules to one clock edge.
  task automatic model_edge();
    if (exc_req) begin
      m_pc  = 32'h0000_4180;
      m_epc = exc_pc;
      m_pv  = 1'b0;
    end else if (eret_req) begin
      m_pc = fix(m_epc);
      m_pv = 1'b0;
    end else if (br_valid && !stall) begin
      m_pc = fix(br_target);
      m_pv = 1'b0;
    end else if (br_valid && stall) begin
      m_pt = br_target;
      m_pv = 1'b1;
    end else if (m_pv && !stall) begin
      m_pc = fix(m_pt);
      m_pv = 1'b0;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".pend"}, {31'b0, redirect_pending}, {31'b0, m_pv});
    check({tag, ".adel"}, {31'b0, fetch_adel}, {31'b0, exp_adel()});
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge,
  // then single-cycle pulses are dropped.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
    br_valid = 1'b0;
    exc_req  = 1'b0;
    eret_req = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    stall     = 1'b0;
    br_valid  = 1'b0;
    br_target = 32'h0;
    exc_req   = 1'b0;
    exc_pc    = 32'h0;
    eret_req  = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    do_reset();
    check("reset.pc_const", pc, 32'h0000_3000);

    // Sequential fetch after reset release.
    tick("seq1");
    tick("seq2");
    tick("seq3");
    check("seq.pc_const", pc, 32'h0000_300C);
    tick("seq4");
    check("seq.pc_3010", pc, 32'h0000_3010);

    // Branch during stall is buffered, then applied on release.
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3400;
    tick("hold1");
    tick("hold2");
    tick("hold3");
    check("hold.pc_const", pc, 32'h0000_3010);
    check("hold.pend_const", {31'b0, redirect_pending}, 32'd1);
    stall = 1'b0;
    tick("release");
    check("release.pc_const", pc, 32'h0000_3400);
    tick("release_next");
    check("release.next_const", pc, 32'h0000_3404);

    // Exception while HOLD, then return.
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3400;
    tick("hold_again");
    exc_req = 1'b1; exc_pc = 32'h0000_3020;
    tick("exc");
    check("exc.pc_const", pc, 32'h0000_4180);
    check("exc.epc_const", epc, 32'h0000_3020);
    stall = 1'b0; eret_req = 1'b1;
    tick("eret");
    check("eret.pc_const", pc, 32'h0000_3020);

    // exc and eret together: exception wins.
    exc_req = 1'b1; exc_pc = 32'h0000_3100;
    tick("exc_epc");
    exc_req = 1'b1; eret_req = 1'b1; exc_pc = 32'h0000_3200;
    tick("exc_eret");
    check("exc_eret.pc_const", pc, 32'h0000_4180);
    check("exc_eret.epc_const", epc, 32'h0000_3200);

    // Wraparound at the top of the address space.
    br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
    tick("wrap_load");
    tick("wrap");
    check("wrap.pc_const", pc, 32'h0000_0000);

    // Reset mid-HOLD drops the buffer at once.
    stall = 1'b1; br_valid = 1'b1; br_target = 32'h0000_3800;
    tick("hold_rst");
    stall = 1'b0;
    do_reset();
    check("rst_hold.pend_const", {31'b0, redirect_pending}, 32'd0);

    // Misaligned branch target.
    br_valid = 1'b1; br_target = 32'h0000_3402;
    tick("misalign");
`ifdef PC_ALIGN_CHECK_EN
    check("misalign.pc_const", pc, 32'h0000_3402);
    check("misalign.adel_const", {31'b0, fetch_adel}, 32'd1);
`else
    check("misalign.pc_const", pc, 32'h0000_3400);
    check("misalign.adel_const", {31'b0, fetch_adel}, 32'd0);
`endif
    tick("misalign_next");
    exc_req = 1'b1; exc_pc = 32'h0000_3406;
    tick("misalign_exc");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      stall     = ($urandom_range(0, 9) < 4);
      br_valid  = ($urandom_range(0, 9) < 2);
      br_target = $urandom;
      exc_req   = ($urandom_range(0, 99) < 3);
      exc_pc    = $urandom;
      eret_req  = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        tick("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
